// File: rtl/ysyx_22051468_pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: default geometry,
// reset PC and the main-slot load source used by the top-level steering logic.
package ysyx_22051468_pipe_stage_reg_pkg;

  localparam int          DEFAULT_PAYLOAD_W = 320;
  localparam int          DEFAULT_PC_W      = 64;
  localparam int          DEFAULT_CNT_W     = 32;
  localparam logic [63:0] DEFAULT_RST_PC    = 64'h0000_0000_8000_0000;

  // Where the main slot takes its next contents from on a given edge.
  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_IN   = 2'd1,
    SRC_SKID = 2'd2,
    SRC_NOP  = 2'd3
  } main_src_e;

  // Steering for the two-slot variant; flush and reset are handled by the slots.
  function automatic main_src_e pick_main_src(
    input logic main_valid,
    input logic skid_valid,
    input logic emit,
    input logic accept
  );
    main_src_e src;
    src = SRC_HOLD;
    if (skid_valid) begin
      if (emit) src = SRC_SKID;
    end else if (!main_valid) begin
      if (accept) src = SRC_IN;
    end else if (emit) begin
      src = accept ? SRC_IN : SRC_NOP;
    end
    return src;
  endfunction

endpackage

// File: rtl/ysyx_22051468_pipe_slot.sv
// One pipeline storage slot: valid flag, instruction address and opaque payload,
// with a load enable and a synchronous clear that turns the slot into a NOP bubble.
module ysyx_22051468_pipe_slot
  import ysyx_22051468_pipe_stage_reg_pkg::*;
#(
  parameter int                   PAYLOAD_W   = DEFAULT_PAYLOAD_W,
  parameter int                   PC_W        = DEFAULT_PC_W,
  parameter logic [PAYLOAD_W-1:0] RST_PAYLOAD = '0,
  parameter logic [PC_W-1:0]      RST_PC      = PC_W'(DEFAULT_RST_PC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 valid_d,
  input  logic [PAYLOAD_W-1:0] payload_d,
  input  logic [PC_W-1:0]      pc_d,
  output logic                 valid_q,
  output logic [PAYLOAD_W-1:0] payload_q,
  output logic [PC_W-1:0]      pc_q
);

  // An empty slot always carries the NOP payload; its pc keeps the last real address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= RST_PAYLOAD;
      pc_q      <= RST_PC;
    end else if (clear) begin
      valid_q   <= 1'b0;
      payload_q <= RST_PAYLOAD;
    end else if (load) begin
      valid_q <= valid_d;
      if (valid_d) begin
        payload_q <= payload_d;
        pc_q      <= pc_d;
      end else begin
        payload_q <= RST_PAYLOAD;
      end
    end
  end

endmodule

// File: rtl/ysyx_22051468_pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, hold and a
// saturating stall counter. Define YSYX_22051468_PIPE_SKID_EN for a registered-ready skid slot.
module ysyx_22051468_pipe_stage_reg
  import ysyx_22051468_pipe_stage_reg_pkg::*;
#(
  parameter int                   PAYLOAD_W   = DEFAULT_PAYLOAD_W,
  parameter int                   PC_W        = DEFAULT_PC_W,
  parameter logic [PAYLOAD_W-1:0] RST_PAYLOAD = '0,
  parameter logic [PC_W-1:0]      RST_PC      = PC_W'(DEFAULT_RST_PC),
  parameter int                   CNT_W       = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 hold_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  input  logic [PC_W-1:0]      in_pc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [PC_W-1:0]      out_pc_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  logic                 main_valid;
  logic [PAYLOAD_W-1:0] main_payload;
  logic [PC_W-1:0]      main_pc;
  logic                 emit;
  main_src_e            main_src;
  logic                 main_load;
  logic                 main_valid_d;
  logic [PAYLOAD_W-1:0] main_payload_d;
  logic [PC_W-1:0]      main_pc_d;
  logic [PAYLOAD_W-1:0] skid_payload;
  logic [PC_W-1:0]      skid_pc;
  logic [CNT_W-1:0]     stall_cnt;

  assign out_valid_o = main_valid & ~hold_i;
  assign emit        = out_valid_o & out_ready_i;

`ifdef YSYX_22051468_PIPE_SKID_EN
  logic skid_valid;
  logic accept;
  logic skid_load;
  logic skid_clear;

  // Ready depends only on flops and the global controls, never on out_ready_i.
  assign in_ready_o = rst_n & ~hold_i & ~flush_i & ~skid_valid;
  assign accept     = in_valid_i & in_ready_o;
  assign skid_load  = accept & main_valid & ~emit;
  assign skid_clear = flush_i | (skid_valid & emit);

  always_comb begin
    main_src = pick_main_src(main_valid, skid_valid, emit, accept);
  end

  ysyx_22051468_pipe_slot #(
    .PAYLOAD_W  (PAYLOAD_W),
    .PC_W       (PC_W),
    .RST_PAYLOAD(RST_PAYLOAD),
    .RST_PC     (RST_PC)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .valid_d  (1'b1),
    .payload_d(in_payload_i),
    .pc_d     (in_pc_i),
    .valid_q  (skid_valid),
    .payload_q(skid_payload),
    .pc_q     (skid_pc)
  );
`else
  assign in_ready_o   = rst_n & ~hold_i & ~flush_i & (~main_valid | out_ready_i);
  assign skid_payload = RST_PAYLOAD;
  assign skid_pc      = RST_PC;

  always_comb begin
    main_src = SRC_HOLD;
    if (in_ready_o) main_src = in_valid_i ? SRC_IN : SRC_NOP;
  end
`endif

  // Translate the chosen source into the main slot's load port.
  always_comb begin
    main_load      = (main_src != SRC_HOLD);
    main_valid_d   = 1'b0;
    main_payload_d = in_payload_i;
    main_pc_d      = in_pc_i;
    case (main_src)
      SRC_IN:   main_valid_d = 1'b1;
      SRC_SKID: begin
        main_valid_d   = 1'b1;
        main_payload_d = skid_payload;
        main_pc_d      = skid_pc;
      end
      default:  main_valid_d = 1'b0;
    endcase
  end

  ysyx_22051468_pipe_slot #(
    .PAYLOAD_W  (PAYLOAD_W),
    .PC_W       (PC_W),
    .RST_PAYLOAD(RST_PAYLOAD),
    .RST_PC     (RST_PC)
  ) u_main (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (main_load),
    .clear    (flush_i),
    .valid_d  (main_valid_d),
    .payload_d(main_payload_d),
    .pc_d     (main_pc_d),
    .valid_q  (main_valid),
    .payload_q(main_payload),
    .pc_q     (main_pc)
  );

  // Counts every cycle a beat is offered but refused, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_payload_o = main_payload;
  assign out_pc_o      = main_pc;
  assign stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_ysyx_22051468_pipe_stage_reg.sv
// Bench for ysyx_22051468_pipe_stage_reg: queue-based reference model compared every cycle,
// plus directed literal checks; builds with or without YSYX_22051468_PIPE_SKID_EN.
module tb_ysyx_22051468_pipe_stage_reg;

  localparam int PW  = 320;
  localparam int PCW = 64;
`ifdef YSYX_22051468_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n, flush, hold, in_valid, out_ready;
  logic [PW-1:0]  in_payload;
  logic [PCW-1:0] in_pc;

  logic           in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [PW-1:0]  out_payload_a, out_payload_b;
  logic [PCW-1:0] out_pc_a, out_pc_b;
  logic [31:0]    stall_a;
  logic [3:0]     stall_b;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  ysyx_22051468_pipe_stage_reg u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .hold_i(hold),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_payload_i(in_payload), .in_pc_i(in_pc),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_payload_o(out_payload_a),
    .out_pc_o(out_pc_a), .stall_cnt_o(stall_a)
  );

  ysyx_22051468_pipe_stage_reg #(.CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .hold_i(hold),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_payload_i(in_payload), .in_pc_i(in_pc),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_payload_o(out_payload_b),
    .out_pc_o(out_pc_b), .stall_cnt_o(stall_b)
  );

  // Reference model: an ordered queue of beats in flight with the stage capacity.
  typedef struct {
    logic [PW-1:0]  p;
    logic [PCW-1:0] pc;
  } beat_t;

  beat_t          q[$];
  beat_t          popped;
  logic [PCW-1:0] m_pc  = 64'h8000_0000;
  logic [63:0]    m_cnt = '0;
  bit             m_ov, m_acc, m_emit;

  function automatic logic [PW-1:0] mkp(input logic [31:0] v);
    return {10{v}};
  endfunction

  function automatic logic [PCW-1:0] mkpc(input logic [31:0] v);
    return 64'h8000_1000 + {30'd0, v, 2'b00};
  endfunction

  function automatic bit m_ready();
    return rst_n && !hold && !flush &&
           (SKID ? (q.size() < 2) : (q.size() == 0 || out_ready));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_pc  = 64'h8000_0000;
      m_cnt = '0;
    end else begin
      m_ov   = (q.size() > 0) && !hold;
      m_acc  = in_valid && m_ready();
      m_emit = m_ov && out_ready;
      if (m_ov && !out_ready && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt = m_cnt + 1;
      if (flush) begin
        q.delete();
      end else if (!hold) begin
        if (m_emit) popped = q.pop_front();
        if (m_acc) q.push_back('{in_payload, in_pc});
      end
      if (q.size() > 0) m_pc = q[0].pc;
    end
  end

  task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      logic [PW-1:0] ep;
      logic [3:0]    eb;
      ep = (q.size() > 0) ? q[0].p : '0;
      eb = (m_cnt > 15) ? 4'hF : m_cnt[3:0];
      checkOutput("model in_ready_a",  PW'(in_ready_a),  PW'(m_ready()));
      checkOutput("model out_valid_a", PW'(out_valid_a), PW'((q.size() > 0) && !hold));
      checkOutput("model payload_a",   out_payload_a,    ep);
      checkOutput("model pc_a",        PW'(out_pc_a),    PW'(m_pc));
      checkOutput("model stall_a",     PW'(stall_a),     PW'(m_cnt[31:0]));
      checkOutput("model in_ready_b",  PW'(in_ready_b),  PW'(m_ready()));
      checkOutput("model out_valid_b", PW'(out_valid_b), PW'((q.size() > 0) && !hold));
      checkOutput("model payload_b",   out_payload_b,    ep);
      checkOutput("model pc_b",        PW'(out_pc_b),    PW'(m_pc));
      checkOutput("model stall_b",     PW'(stall_b),     PW'(eb));
    end
  end

  // Drives one cycle of inputs, then returns just after the following posedge.
  task automatic applyStimulus(input logic r, input logic f, input logic h,
                               input logic iv, input logic [31:0] v, input logic ordy);
    rst_n      = r;
    flush      = f;
    hold       = h;
    in_valid   = iv;
    in_payload = mkp(v);
    in_pc      = mkpc(v);
    out_ready  = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("reset out_valid", PW'(out_valid_a), '0);
    checkOutput("reset out_pc",    PW'(out_pc_a),    PW'(64'h8000_0000));
    checkOutput("reset payload",   out_payload_a,    '0);
    checkOutput("reset stall",     PW'(stall_a),     '0);
    checkOutput("reset in_ready",  PW'(in_ready_a),  '0);

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, i, 1'b1);
      checkOutput("stream valid",   PW'(out_valid_a), PW'(1));
      checkOutput("stream payload", out_payload_a,    mkp(i));
      checkOutput("stream pc",      PW'(out_pc_a),    PW'(mkpc(i)));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("stream drained", PW'(out_valid_a), '0);

    // Backpressure: A held three cycles while B is offered
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    checkOutput("bp stall",     PW'(stall_a),  PW'(3));
    checkOutput("bp payload A", out_payload_a, mkp(32'hA));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 1'b1);
    checkOutput("bp payload B", out_payload_a, mkp(32'hB));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("bp drained", PW'(out_valid_a), '0);
    checkOutput("bp stall kept", PW'(stall_a), PW'(3));

    // Flush with C in main and D pending
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hD, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hD, 1'b0);
    checkOutput("flush valid",   PW'(out_valid_a), '0);
    checkOutput("flush payload", out_payload_a,    '0);
    checkOutput("flush pc",      PW'(out_pc_a),    PW'(mkpc(32'hC)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("flush ready after", PW'(in_ready_a), PW'(1));
    checkOutput("flush stall",       PW'(stall_a),    PW'(5));

    // Hold freezes E, then flush beats hold
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hE, 1'b1);
    repeat (2) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("hold valid",   PW'(out_valid_a), '0);
      checkOutput("hold payload", out_payload_a,    mkp(32'hE));
      checkOutput("hold stall",   PW'(stall_a),     PW'(5));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("hold released", PW'(out_valid_a), '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hF, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("flush+hold payload", out_payload_a, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("flush+hold empty", PW'(out_valid_a), '0);

    // Saturation of the 4-bit counter
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("sat reset", PW'(stall_b), '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("sat stall_b", PW'(stall_b), PW'(15));
    checkOutput("sat stall_a", PW'(stall_a), PW'(20));
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("sat stall_b stays", PW'(stall_b), PW'(15));
    checkOutput("sat stall_a grows", PW'(stall_a), PW'(23));

    // Mixed traffic checked by the model only
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom % 60) != 0, ($urandom % 16) == 0, ($urandom % 8) == 0,
                    $urandom % 2, $urandom, ($urandom % 3) != 0);
    end
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
